// File: rtl/contador_microprograma.sv
// contador_microprograma
//   Microprogram address counter for the control ROM. Each enabled cycle it
//   either loads a branch target from the condition mux (carga) or advances by
//   one. An optional return stack supports nested subroutine calls.
//
//   Optional feature macro: SUBR_STACK_EN
//     defined   -> return stack, llamada/retorno handling, sticky error_pila
//     undefined -> no stack; llamada/retorno ignored; error_pila tied to 0
//
// Parameters
//   AW         address width of direccion / dir_salto
//   RESET_ADDR address forced while reset is high
//   PILA_PROF  return stack depth (2..16), only used with SUBR_STACK_EN
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   hab        count enable; 0 holds all state and clears desborde
//   carga      load request (mux output)
//   dir_salto  branch / call target
//   llamada    with carga: push return address (direccion + 1)
//   retorno    pop return address into direccion (highest priority)
//   direccion  registered microinstruction address
//   desborde   one-cycle pulse when an increment wraps to 0
//   error_pila sticky stack overflow / underflow flag

module contador_microprograma #(
  parameter int unsigned    AW         = 8,
  parameter logic [AW-1:0]  RESET_ADDR = '0,
  parameter int unsigned    PILA_PROF  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hab,
  input  logic          carga,
  input  logic [AW-1:0] dir_salto,
  input  logic          llamada,
  input  logic          retorno,
  output logic [AW-1:0] direccion,
  output logic          desborde,
  output logic          error_pila
);

  logic [AW-1:0] direccion_q, direccion_d;
  logic          desborde_q, desborde_d;

  // Carry out of the increment is exactly the wrap condition.
  logic [AW:0]   incremento;
  assign incremento = {1'b0, direccion_q} + {{AW{1'b0}}, 1'b1};

`ifdef SUBR_STACK_EN

  localparam int unsigned SpW = $clog2(PILA_PROF + 1);

  logic [SpW-1:0] sp_q, sp_d;
  logic           error_q, error_d;
  logic           push;
  logic [AW-1:0]  pila_q [PILA_PROF];
  logic [AW-1:0]  tope;
  logic           pila_vacia, pila_llena;

  assign pila_vacia = (sp_q == '0);
  assign pila_llena = (sp_q == SpW'(PILA_PROF));

  // Entry below the stack pointer; mux form keeps the index in range.
  always_comb begin
    tope = '0;
    for (int i = 0; i < int'(PILA_PROF); i++) begin
      if (sp_q == SpW'(i + 1)) begin
        tope = pila_q[i];
      end
    end
  end

  always_comb begin
    direccion_d = direccion_q;
    desborde_d  = 1'b0;
    sp_d        = sp_q;
    error_d     = error_q;
    push        = 1'b0;
    if (hab) begin
      if (retorno && !pila_vacia) begin
        direccion_d = tope;
        sp_d        = sp_q - SpW'(1);
      end else if (retorno) begin
        // Underflow: behave like a plain increment, including wrap.
        error_d                   = 1'b1;
        {desborde_d, direccion_d} = incremento;
      end else if (carga) begin
        direccion_d = dir_salto;
        if (llamada) begin
          if (pila_llena) begin
            // Overflow: jump still taken, return address dropped.
            error_d = 1'b1;
          end else begin
            push = 1'b1;
            sp_d = sp_q + SpW'(1);
          end
        end
      end else begin
        {desborde_d, direccion_d} = incremento;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q    <= '0;
      error_q <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      error_q <= error_d;
    end
  end

  // Stack contents need no reset; sp alone defines what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(PILA_PROF); i++) begin
      if (push && (sp_q == SpW'(i))) begin
        pila_q[i] <= incremento[AW-1:0];
      end
    end
  end

  assign error_pila = error_q;

`else

  always_comb begin
    direccion_d = direccion_q;
    desborde_d  = 1'b0;
    if (hab) begin
      if (carga) begin
        direccion_d = dir_salto;
      end else begin
        {desborde_d, direccion_d} = incremento;
      end
    end
  end

  // Call/return inputs stay on the port list but have no effect here.
  logic unused_subr;
  assign unused_subr = llamada ^ retorno;

  assign error_pila = 1'b0;

`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      direccion_q <= RESET_ADDR;
      desborde_q  <= 1'b0;
    end else begin
      direccion_q <= direccion_d;
      desborde_q  <= desborde_d;
    end
  end

  assign direccion = direccion_q;
  assign desborde  = desborde_q;

endmodule

// File: tb/tb_contador_microprograma.sv
module tb_contador_microprograma;

  localparam int AW   = 8;
  localparam int PROF = 4;
  localparam int MOD  = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          hab;
  logic          carga;
  logic [AW-1:0] dir_salto;
  logic          llamada;
  logic          retorno;
  logic [AW-1:0] direccion;
  logic          desborde;
  logic          error_pila;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  contador_microprograma #(
    .AW        (AW),
    .RESET_ADDR(8'h00),
    .PILA_PROF (PROF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hab       (hab),
    .carga     (carga),
    .dir_salto (dir_salto),
    .llamada   (llamada),
    .retorno   (retorno),
    .direccion (direccion),
    .desborde  (desborde),
    .error_pila(error_pila)
  );

  // Reference model: integer address, queue as return stack.
  int m_dir;
  bit m_desb;
  bit m_err;
  int m_pila[$];

  task automatic model_reset();
    m_dir  = 0;
    m_desb = 1'b0;
    m_err  = 1'b0;
    m_pila.delete();
  endtask

  task automatic model_inc();
    m_desb = (m_dir == MOD - 1);
    m_dir  = (m_dir + 1) % MOD;
  endtask

  task automatic model_step(input bit h, input bit c, input int d, input bit l, input bit r);
    if (!h) begin
      m_desb = 1'b0;
      return;
    end
`ifdef SUBR_STACK_EN
    if (r) begin
      if (m_pila.size() > 0) begin
        m_dir  = m_pila.pop_back();
        m_desb = 1'b0;
      end else begin
        m_err = 1'b1;
        model_inc();
      end
    end else if (c) begin
      if (l) begin
        if (m_pila.size() < PROF) m_pila.push_back((m_dir + 1) % MOD);
        else m_err = 1'b1;
      end
      m_dir  = d;
      m_desb = 1'b0;
    end else begin
      model_inc();
    end
`else
    if (c) begin
      m_dir  = d;
      m_desb = 1'b0;
    end else begin
      model_inc();
    end
`endif
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic cycle(input bit h, input bit c, input int d, input bit l, input bit r);
    hab       = h;
    carga     = c;
    dir_salto = AW'(d);
    llamada   = l;
    retorno   = r;
    @(posedge clk);
    #1;
    model_step(h, c, d, l, r);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    hab = 1'b0; carga = 1'b0; dir_salto = '0; llamada = 1'b0; retorno = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    n_checks++;
    if (direccion !== 8'h00 || desborde !== 1'b0 || error_pila !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: dir=%h desb=%b err=%b, expected 00 0 0",
               direccion, desborde, error_pila);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0);
    // Asynchronous reset in the middle of a cycle.
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (direccion !== 8'h00 || desborde !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_async: dir=%h desb=%b, expected 00 0", direccion, desborde);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_count();
    for (int i = 1; i <= 3; i++) begin
      cycle(1, 0, 0, 0, 0);
      n_checks++;
      if (direccion !== AW'(i) || desborde !== 1'b0) begin
        n_errors++;
        $display("FAIL count_%0d: dir=%h desb=%b, expected %h 0", i, direccion, desborde, AW'(i));
      end
    end
  endtask

  task automatic test_load_hold();
    cycle(1, 1, 'h10, 0, 0);
    cycle(1, 1, 'hA5, 0, 0);
    n_checks++;
    if (direccion !== 8'hA5) begin
      n_errors++;
      $display("FAIL load: dir=%h, expected a5", direccion);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(0, 1, 'h33, 1, 1);
      n_checks++;
      if (direccion !== 8'hA5 || desborde !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_%0d: dir=%h desb=%b, expected a5 0", i, direccion, desborde);
      end
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_dir [4];
    logic          exp_desb [4];
    exp_dir  = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    exp_desb = '{1'b0, 1'b0, 1'b1, 1'b0};
    cycle(1, 1, 'hFE, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cycle(1, 0, 0, 0, 0);
      n_checks++;
      if (direccion !== exp_dir[i] || desborde !== exp_desb[i]) begin
        n_errors++;
        $display("FAIL wrap_%0d: dir=%h desb=%b, expected %h %b",
                 i, direccion, desborde, exp_dir[i], exp_desb[i]);
      end
    end
    cycle(1, 1, 'hFF, 0, 0);
    cycle(1, 1, 'h00, 0, 0);
    n_checks++;
    if (direccion !== 8'h00 || desborde !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_load0: dir=%h desb=%b, expected 00 0", direccion, desborde);
    end
    // Wrap pulse followed by a disabled cycle must drop desborde.
    cycle(1, 1, 'hFF, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (direccion !== 8'h00 || desborde !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_hold: dir=%h desb=%b, expected 00 0", direccion, desborde);
    end
  endtask

`ifdef SUBR_STACK_EN
  task automatic test_subr();
    cycle(1, 1, 'h20, 0, 0);
    cycle(1, 1, 'h80, 1, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    n_checks++;
    if (direccion !== 8'h82) begin
      n_errors++;
      $display("FAIL subr_body: dir=%h, expected 82", direccion);
    end
    cycle(1, 1, 'h55, 1, 1);
    n_checks++;
    if (direccion !== 8'h21 || error_pila !== 1'b0) begin
      n_errors++;
      $display("FAIL subr_return: dir=%h err=%b, expected 21 0", direccion, error_pila);
    end
  endtask

  task automatic test_stack_limits();
    logic [AW-1:0] exp_ret [5];
    exp_ret = '{8'h71, 8'h61, 8'h51, 8'h41, 8'h42};
    cycle(1, 1, 'h40, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 'h50 + 16 * i, 1, 0);
      n_checks++;
      if (direccion !== AW'('h50 + 16 * i) || error_pila !== (i == 4)) begin
        n_errors++;
        $display("FAIL call_%0d: dir=%h err=%b, expected %h %b",
                 i, direccion, error_pila, AW'('h50 + 16 * i), (i == 4));
      end
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 0, 1);
      n_checks++;
      if (direccion !== exp_ret[i] || error_pila !== 1'b1 || desborde !== 1'b0) begin
        n_errors++;
        $display("FAIL ret_%0d: dir=%h err=%b desb=%b, expected %h 1 0",
                 i, direccion, error_pila, desborde, exp_ret[i]);
      end
    end
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
    n_checks++;
    if (error_pila !== 1'b0 || direccion !== 8'h00) begin
      n_errors++;
      $display("FAIL err_clear: err=%b dir=%h, expected 0 00", error_pila, direccion);
    end
  endtask
`else
  task automatic test_no_stack();
    cycle(1, 1, 'h30, 0, 0);
    cycle(1, 1, 'h44, 1, 1);
    n_checks++;
    if (direccion !== 8'h44 || error_pila !== 1'b0) begin
      n_errors++;
      $display("FAIL nostack_load: dir=%h err=%b, expected 44 0", direccion, error_pila);
    end
    cycle(1, 0, 'h99, 0, 1);
    cycle(1, 0, 'h99, 1, 0);
    n_checks++;
    if (direccion !== 8'h46 || error_pila !== 1'b0) begin
      n_errors++;
      $display("FAIL nostack_inc: dir=%h err=%b, expected 46 0", direccion, error_pila);
    end
  endtask
`endif

  task automatic test_random();
    bit h, c, l, r;
    int d;
    for (int n = 0; n < 600; n++) begin
      h = ($urandom_range(7) != 0);
      c = ($urandom_range(3) == 0);
      l = $urandom_range(1);
      r = ($urandom_range(7) == 0);
      // Bias targets toward the top of the range so wraps happen often.
      d = ($urandom_range(1) == 0) ? $urandom_range(255) : $urandom_range(255, 250);
      if ($urandom_range(99) == 0) begin
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
      end
      cycle(h, c, d, l, r);
      n_checks++;
      if (direccion !== AW'(m_dir) || desborde !== m_desb || error_pila !== m_err) begin
        n_errors++;
        $display("FAIL random_%0d: dir=%h desb=%b err=%b, expected %h %b %b",
                 n, direccion, desborde, error_pila, AW'(m_dir), m_desb, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_load_hold();
    test_wrap();
`ifdef SUBR_STACK_EN
    test_subr();
    test_stack_limits();
`else
    test_no_stack();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
